// File: rtl/flappy_pkg.sv
// Shared types for the pipe scheduler: per-slot pipe record, scheduler states,
// coordinate widths and the gap clamp helper.
package flappy_pkg;

    localparam int X_W   = 11;
    localparam int GAP_W = 10;

    typedef struct packed {
        logic                  valid;
        logic signed [X_W-1:0] x;
        logic [GAP_W-1:0]      gap;
        logic                  scored;
    } pipe_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2
    } sched_state_e;

    function automatic logic [GAP_W-1:0] clamp_gap(input logic [GAP_W-1:0] v,
                                                   input int lo, input int hi);
        if (int'(v) < lo)
            return GAP_W'(lo);
        else if (int'(v) > hi)
            return GAP_W'(hi);
        else
            return v;
    endfunction

endpackage

// File: rtl/pipe_scheduler.sv
// Pipe ring for the flappy game: spawns pipes with rng gaps, scrolls them each
// frame tick, retires them off the left edge and flags pipes passing the bird.
module pipe_scheduler
    import flappy_pkg::*;
#(
    parameter int MAX_PIPES   = 4,
    parameter int SCREEN_W    = 640,
    parameter int PIPE_W      = 52,
    parameter int SPEED       = 4,
    parameter int SPAWN_TICKS = 60,
    parameter int GAP_MIN     = 20,
    parameter int GAP_MAX     = 147,
    parameter int BIRD_X      = 100,
    localparam int IW         = $clog2(MAX_PIPES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  game_over,
    input  logic [GAP_W-1:0]      rand_in,
    input  logic [IW-1:0]         rd_idx,
    output logic                  rd_valid,
    output logic signed [X_W-1:0] rd_x,
    output logic [GAP_W-1:0]      rd_gap,
    output logic [IW:0]           pipe_count,
    output logic                  rand_take,
    output logic                  score_pulse,
    output logic                  running
);

    localparam int CW = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam logic [CW-1:0] SPAWN_LAST = CW'(SPAWN_TICKS - 1);

    sched_state_e  state_q, state_d;
    pipe_t         slots_q [MAX_PIPES];
    pipe_t         slots_d [MAX_PIPES];
    logic [IW-1:0] head_q, head_d;
    logic [IW:0]   count_q, count_d;
    logic [CW-1:0] spawn_cnt_q, spawn_cnt_d;
    logic          rand_take_q, rand_take_d;
    logic          score_pulse_q, score_pulse_d;

    logic [IW-1:0] tail;
    logic [IW-1:0] age_idx;
    logic          scored_found;
    logic [IW-1:0] rd_slot;

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        count_d       = count_q;
        spawn_cnt_d   = spawn_cnt_q;
        slots_d       = slots_q;
        rand_take_d   = 1'b0;
        score_pulse_d = 1'b0;
        scored_found  = 1'b0;
        age_idx       = '0;
        // Tail is unaffected by a same-tick retire: head+1 plus count-1.
        tail          = head_q + count_q[IW-1:0];

        case (state_q)
            IDLE, FREEZE: begin
                if (start) begin
                    state_d     = RUN;
                    head_d      = '0;
                    count_d     = '0;
                    spawn_cnt_d = SPAWN_LAST;
                    for (int i = 0; i < MAX_PIPES; i++)
                        slots_d[i] = '0;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = FREEZE;
                end else if (tick) begin
                    for (int i = 0; i < MAX_PIPES; i++)
                        if (slots_q[i].valid)
                            slots_d[i].x = slots_q[i].x - X_W'(SPEED);

                    // Walk in age order so the oldest unscored pipe wins.
                    for (int a = 0; a < MAX_PIPES; a++) begin
                        age_idx = head_q + IW'(a);
                        if (!scored_found && ((IW+1)'(a) < count_q) &&
                            slots_d[age_idx].valid && !slots_d[age_idx].scored &&
                            (int'($signed(slots_d[age_idx].x)) + PIPE_W < BIRD_X)) begin
                            slots_d[age_idx].scored = 1'b1;
                            score_pulse_d           = 1'b1;
                            scored_found            = 1'b1;
                        end
                    end

                    if ((count_q != '0) && slots_d[head_q].valid &&
                        (int'($signed(slots_d[head_q].x)) <= -PIPE_W)) begin
                        slots_d[head_q].valid = 1'b0;
                        head_d                = head_q + 1'b1;
                        count_d               = count_q - 1'b1;
                    end

                    // A full ring parks the counter at its last value until room frees.
                    if (spawn_cnt_q == SPAWN_LAST) begin
                        if (count_d < (IW+1)'(MAX_PIPES)) begin
                            slots_d[tail] = '{valid:  1'b1,
                                              x:      X_W'(SCREEN_W),
                                              gap:    clamp_gap(rand_in, GAP_MIN, GAP_MAX),
                                              scored: 1'b0};
                            rand_take_d   = 1'b1;
                            spawn_cnt_d   = '0;
                            count_d       = count_d + 1'b1;
                        end
                    end else begin
                        spawn_cnt_d = spawn_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            head_q        <= '0;
            count_q       <= '0;
            spawn_cnt_q   <= '0;
            rand_take_q   <= 1'b0;
            score_pulse_q <= 1'b0;
            for (int i = 0; i < MAX_PIPES; i++)
                slots_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            count_q       <= count_d;
            spawn_cnt_q   <= spawn_cnt_d;
            rand_take_q   <= rand_take_d;
            score_pulse_q <= score_pulse_d;
            slots_q       <= slots_d;
        end
    end

    assign rd_slot = head_q + rd_idx;

    always_comb begin
        rd_valid = 1'b0;
        rd_x     = '0;
        rd_gap   = '0;
        if ({1'b0, rd_idx} < count_q) begin
            rd_valid = slots_q[rd_slot].valid;
            rd_x     = slots_q[rd_slot].x;
            rd_gap   = slots_q[rd_slot].gap;
        end
    end

    assign pipe_count  = count_q;
    assign rand_take   = rand_take_q;
    assign score_pulse = score_pulse_q;
    assign running     = (state_q == RUN);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: default-size instance for spawn/scroll/score/freeze,
// small instance (2 slots, 4-tick spawn) for ring saturation.
module tb_pipe_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              tick = 0, start = 0, game_over = 0;
    logic [9:0]        rand_in = '0;
    logic [1:0]        rd_idx = '0;
    logic              rd_valid, rand_take, score_pulse, running;
    logic signed [10:0] rd_x;
    logic [9:0]        rd_gap;
    logic [2:0]        pipe_count;

    logic              s_tick = 0, s_start = 0, s_game_over = 0;
    logic [9:0]        s_rand_in = '0;
    logic [0:0]        s_rd_idx = '0;
    logic              s_rd_valid, s_rand_take, s_score_pulse, s_running;
    logic signed [10:0] s_rd_x;
    logic [9:0]        s_rd_gap;
    logic [1:0]        s_pipe_count;

    pipe_scheduler u_dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .game_over(game_over),
        .rand_in(rand_in), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_x(rd_x),
        .rd_gap(rd_gap), .pipe_count(pipe_count), .rand_take(rand_take),
        .score_pulse(score_pulse), .running(running)
    );

    pipe_scheduler #(.MAX_PIPES(2), .SPAWN_TICKS(4)) u_small (
        .clk(clk), .rst(rst), .tick(s_tick), .start(s_start), .game_over(s_game_over),
        .rand_in(s_rand_in), .rd_idx(s_rd_idx), .rd_valid(s_rd_valid), .rd_x(s_rd_x),
        .rd_gap(s_rd_gap), .pipe_count(s_pipe_count), .rand_take(s_rand_take),
        .score_pulse(s_score_pulse), .running(s_running)
    );

    int n_vec = 0, n_err = 0;
    int m_vec = 0, m_err = 0;
    int tick_no = 0;
    int q_take[$], q_score[$], q_stake[$], q_sscore[$];
    int saved_x0;

    // Each pulse pops the tick number at which it was predicted.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (rand_take) begin
                m_vec++;
                if (q_take.size() == 0) begin
                    m_err++; $display("FAIL take_pulse: seen at tick %0d, want none", tick_no);
                end else begin
                    e = q_take.pop_front();
                    if (e != tick_no) begin m_err++; $display("FAIL take_pulse: seen at tick %0d, want tick %0d", tick_no, e); end
                end
            end
            if (score_pulse) begin
                m_vec++;
                if (q_score.size() == 0) begin
                    m_err++; $display("FAIL score_pulse: seen at tick %0d, want none", tick_no);
                end else begin
                    e = q_score.pop_front();
                    if (e != tick_no) begin m_err++; $display("FAIL score_pulse: seen at tick %0d, want tick %0d", tick_no, e); end
                end
            end
            if (s_rand_take) begin
                m_vec++;
                if (q_stake.size() == 0) begin
                    m_err++; $display("FAIL small_take_pulse: seen at tick %0d, want none", tick_no);
                end else begin
                    e = q_stake.pop_front();
                    if (e != tick_no) begin m_err++; $display("FAIL small_take_pulse: seen at tick %0d, want tick %0d", tick_no, e); end
                end
            end
            if (s_score_pulse) begin
                m_vec++;
                if (q_sscore.size() == 0) begin
                    m_err++; $display("FAIL small_score_pulse: seen at tick %0d, want none", tick_no);
                end else begin
                    e = q_sscore.pop_front();
                    if (e != tick_no) begin m_err++; $display("FAIL small_score_pulse: seen at tick %0d, want tick %0d", tick_no, e); end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick_big();
        @(posedge clk); #1; tick = 1; tick_no++;
        @(posedge clk); #1; tick = 0;
    endtask

    task automatic tick_small();
        @(posedge clk); #1; s_tick = 1; tick_no++;
        @(posedge clk); #1; s_tick = 0;
    endtask

    task automatic ctrl(input logic st, input logic go);
        @(posedge clk); #1; start = st; game_over = go;
        @(posedge clk); #1; start = 0; game_over = 0;
    endtask

    task automatic rd(input int idx);
        rd_idx = 2'(idx); #1;
    endtask

    task automatic restart(input logic [9:0] r);
        ctrl(0, 1);
        ctrl(1, 0);
        tick_no = 0;
        rand_in = r;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", int'(pipe_count), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_valid", int'(rd_valid), 0);
        rst = 0;
        @(posedge clk); #1;
        chk("idle_pulses", int'(rand_take) + int'(score_pulse), 0);

        tick_big();
        chk("idle_tick_count", int'(pipe_count), 0);

        ctrl(1, 0);
        chk("start_running", int'(running), 1);
        tick_no = 0;
        rand_in = 10'd200;
        q_take.push_back(1);
        tick_big();
        rd(0);
        chk("first_count", int'(pipe_count), 1);
        chk("first_x", int'(rd_x), 640);
        chk("gap_clamp_hi", int'(rd_gap), 147);
        chk("first_valid", int'(rd_valid), 1);
        rd(1);
        chk("empty_slot_valid", int'(rd_valid), 0);

        restart(10'd5);
        chk("restart_count", int'(pipe_count), 0);
        q_take.push_back(1);
        tick_big();
        rd(0);
        chk("gap_clamp_lo", int'(rd_gap), 20);

        restart(10'd90);
        q_take.push_back(1); q_take.push_back(61); q_take.push_back(121); q_take.push_back(181);
        q_score.push_back(150); q_score.push_back(210);
        tick_big();
        rd(0);
        chk("gap_pass", int'(rd_gap), 90);
        rand_in = 10'd147;
        for (int t = 2; t <= 215; t++) begin
            tick_big();
            case (t)
                11:  begin rd(0); chk("scroll_x_t11", int'(rd_x), 600); end
                60:  chk("count_t60", int'(pipe_count), 1);
                61:  begin
                         chk("count_t61", int'(pipe_count), 2);
                         rd(1); chk("spawn2_x", int'(rd_x), 640); chk("spawn2_gap", int'(rd_gap), 147);
                         rd(0); chk("old_x_t61", int'(rd_x), 400);
                     end
                173: begin chk("count_t173", int'(pipe_count), 3); rd(0); chk("head_x_t173", int'(rd_x), -48); end
                174: begin chk("count_retire", int'(pipe_count), 2); rd(0); chk("head_x_t174", int'(rd_x), 188); end
                181: chk("count_t181", int'(pipe_count), 3);
                default: ;
            endcase
        end
        chk("take_q_drained", q_take.size(), 0);
        chk("score_q_drained", q_score.size(), 0);

        #2; rst = 1; #1;
        chk("async_rst_count", int'(pipe_count), 0);
        chk("async_rst_running", int'(running), 0);
        rd(0);
        chk("async_rst_valid", int'(rd_valid), 0);
        @(posedge clk); #1;
        chk("rst_pulses", int'(rand_take) + int'(score_pulse), 0);
        rst = 0;

        ctrl(1, 0);
        tick_no = 0;
        rand_in = 10'd50;
        q_take.push_back(1); q_take.push_back(61);
        repeat (61) tick_big();
        chk("pre_freeze_count", int'(pipe_count), 2);
        rd(0); saved_x0 = int'(rd_x);
        chk("pre_freeze_x", saved_x0, 400);
        ctrl(0, 1);
        chk("freeze_running", int'(running), 0);
        repeat (20) tick_big();
        rd(0); chk("freeze_x0", int'(rd_x), 400);
        rd(1); chk("freeze_x1", int'(rd_x), 640);
        chk("freeze_gap1", int'(rd_gap), 50);
        chk("freeze_count", int'(pipe_count), 2);
        ctrl(1, 0);
        chk("unfreeze_running", int'(running), 1);
        chk("unfreeze_count", int'(pipe_count), 0);
        ctrl(1, 1);
        chk("run_go_wins", int'(running), 0);
        ctrl(1, 1);
        chk("freeze_start_wins", int'(running), 1);
        chk("take_q_drained2", q_take.size(), 0);

        @(posedge clk); #1; s_start = 1;
        @(posedge clk); #1; s_start = 0;
        tick_no = 0;
        s_rand_in = 10'd300;
        q_stake.push_back(1); q_stake.push_back(5); q_stake.push_back(174);
        q_sscore.push_back(150); q_sscore.push_back(154);
        for (int t = 1; t <= 174; t++) begin
            tick_small();
            case (t)
                5:   chk("small_count_t5", int'(s_pipe_count), 2);
                9:   chk("small_full_t9", int'(s_pipe_count), 2);
                173: chk("small_count_t173", int'(s_pipe_count), 2);
                174: begin
                         chk("small_retire_spawn", int'(s_pipe_count), 2);
                         s_rd_idx = 1'b1; #1;
                         chk("small_new_x", int'(s_rd_x), 640);
                         chk("small_new_gap", int'(s_rd_gap), 147);
                         s_rd_idx = 1'b0; #1;
                         chk("small_head_x", int'(s_rd_x), -36);
                     end
                default: ;
            endcase
        end
        @(posedge clk); #1;
        chk("small_take_q_drained", q_stake.size(), 0);
        chk("small_score_q_drained", q_sscore.size(), 0);

        n_vec += m_vec;
        n_err += m_err;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
